// File: rtl/directory_request_sequencer.sv
// Per-node request queues feeding an MSI directory; grant->lookup->update->reply is 4 cycles after push, plus 1 + ack wait for remote actions.
// req_ready drops while a node queue is full (no same-cycle bypass); REMOTE_TIMEOUT_EN bounds the remote ack wait to 15 cycles.
module directory_request_sequencer #(
    parameter int NUM_BLOCKS = 4,
    parameter int ADDR_W     = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [3:0]            req_type,
    input  logic [2*ADDR_W-1:0]   req_addr,
    output logic                  dir_requester,
    output logic                  dir_read_miss,
    output logic                  dir_write_miss,
    output logic                  dir_write_back,
    output logic [1:0]            dir_state,
    output logic [3:0]            dir_sharers,
    input  logic [1:0]            dir_new_state,
    input  logic [3:0]            dir_new_sharers,
    input  logic                  dir_fetch,
    input  logic                  dir_invalidate,
    input  logic                  dir_reply,
    output logic                  remote_fetch,
    output logic                  remote_inval,
    output logic                  remote_node,
    output logic [ADDR_W-1:0]     remote_addr,
    input  logic                  remote_ack,
    output logic                  reply_valid,
    output logic                  reply_node,
    output logic [ADDR_W-1:0]     reply_addr,
    output logic                  busy
`ifdef REMOTE_TIMEOUT_EN
    ,
    output logic                  remote_timeout
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 + ADDR_W;
    localparam int unsigned NB = NUM_BLOCKS;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOOKUP, REMOTE, UPDATE, REPLY} state_t;

    state_t              state;
    logic [EW-1:0]       fifo_mem [2][FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr [2];
    logic [PW-1:0]       rd_ptr [2];
    logic [PW:0]         count  [2];
    logic [1:0]          push, pop, nonempty;
    logic                grant_vld, grant_node, rr_ptr;
    logic [EW-1:0]       head;

    logic                node_q;
    logic [1:0]          type_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          new_state_q;
    logic [3:0]          new_sh_q;
    logic                fetch_q, inval_q, reply_q;
    logic [1:0]          tbl_state [NUM_BLOCKS];
    logic [3:0]          tbl_sh    [NUM_BLOCKS];
    logic                in_range, need_remote;
    logic [1:0]          entry_state;
    logic [3:0]          entry_sh;
`ifdef REMOTE_TIMEOUT_EN
    logic [3:0]          to_cnt;
`endif

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            req_ready[n] = (count[n] != FULL_CNT);
            nonempty[n]  = (count[n] != '0);
            push[n]      = req_valid[n] & req_ready[n] & (req_type[2*n +: 2] != 2'b11);
        end
    end

    // Round-robin pointer only matters when both queues hold work.
    assign grant_vld  = (state == IDLE) & (|nonempty);
    assign grant_node = (&nonempty) ? rr_ptr : nonempty[1];
    assign pop[0]     = grant_vld & ~grant_node;
    assign pop[1]     = grant_vld & grant_node;
    assign head       = fifo_mem[grant_node][rd_ptr[grant_node]];

    always_ff @(posedge clock) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n])
                fifo_mem[n][wr_ptr[n]] <= {req_type[2*n +: 2], req_addr[ADDR_W*n +: ADDR_W]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < 2; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
                if (pop[n])  rd_ptr[n] <= rd_ptr[n] + 1'b1;
                if (push[n] && !pop[n])      count[n] <= count[n] + 1'b1;
                else if (!push[n] && pop[n]) count[n] <= count[n] - 1'b1;
            end
        end
    end

    // Blocks beyond the table read as UNCACHED and are never written.
    assign in_range    = (32'(addr_q) < NB);
    assign entry_state = in_range ? tbl_state[addr_q] : 2'b01;
    assign entry_sh    = in_range ? tbl_sh[addr_q]    : 4'b0000;
    assign need_remote = (dir_fetch | dir_invalidate) & (node_q ? entry_sh[0] : entry_sh[1]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            node_q      <= 1'b0;
            type_q      <= 2'b00;
            addr_q      <= '0;
            new_state_q <= 2'b00;
            new_sh_q    <= 4'b0000;
            fetch_q     <= 1'b0;
            inval_q     <= 1'b0;
            reply_q     <= 1'b0;
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                tbl_state[b] <= 2'b01;
                tbl_sh[b]    <= 4'b0000;
            end
`ifdef REMOTE_TIMEOUT_EN
            to_cnt         <= 4'd0;
            remote_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (grant_vld) begin
                    node_q <= grant_node;
                    type_q <= head[EW-1 -: 2];
                    addr_q <= head[ADDR_W-1:0];
                    if (&nonempty) rr_ptr <= ~rr_ptr;
                    state  <= LOOKUP;
                end
                LOOKUP: begin
                    new_state_q <= dir_new_state;
                    new_sh_q    <= dir_new_sharers;
                    fetch_q     <= dir_fetch;
                    inval_q     <= dir_invalidate;
                    reply_q     <= dir_reply;
`ifdef REMOTE_TIMEOUT_EN
                    to_cnt      <= 4'd0;
`endif
                    state       <= need_remote ? REMOTE : UPDATE;
                end
                REMOTE: begin
                    if (remote_ack) begin
                        state <= UPDATE;
`ifdef REMOTE_TIMEOUT_EN
                    end else if (to_cnt == 4'd14) begin
                        remote_timeout <= 1'b1;
                        state          <= UPDATE;
                    end else begin
                        to_cnt <= to_cnt + 4'd1;
`endif
                    end
                end
                UPDATE: begin
                    if (in_range && new_state_q != 2'b00) begin
                        tbl_state[addr_q] <= new_state_q;
                        tbl_sh[addr_q]    <= new_sh_q;
                    end
                    state <= reply_q ? REPLY : IDLE;
                end
                REPLY:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dir_requester  = node_q;
        dir_read_miss  = (state == LOOKUP) && (type_q == 2'b00);
        dir_write_miss = (state == LOOKUP) && (type_q == 2'b01);
        dir_write_back = (state == LOOKUP) && (type_q == 2'b10);
        dir_state      = (state == LOOKUP) ? entry_state : 2'b01;
        dir_sharers    = (state == LOOKUP) ? entry_sh : 4'b0000;
        remote_fetch   = (state == REMOTE) & fetch_q;
        remote_inval   = (state == REMOTE) & inval_q;
        remote_node    = (state == REMOTE) & ~node_q;
        remote_addr    = (state == REMOTE) ? addr_q : '0;
        reply_valid    = (state == REPLY);
        reply_node     = (state == REPLY) & node_q;
        reply_addr     = (state == REPLY) ? addr_q : '0;
        busy           = (state != IDLE);
    end

endmodule
